control_unit: RTL and testbench

//  Hardwired step sequencer for the Mini SRC DataPath. It drives every DataPath control strobe

---
 rtl/cpu_ctrl_pkg.sv | 67 ++++++
 rtl/cu_op_class.sv | 33 +++
 rtl/control_unit.sv | 161 ++++++++++++++++
 tb/tb_control_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the Mini SRC hardwired control unit: opcodes,
// step-state encodings, opcode classes and the per-class final step.
package cpu_ctrl_pkg;

    localparam int IR_W    = 32;
    localparam int OP_W    = 5;
    localparam int STATE_W = 4;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
    localparam logic [OP_W-1:0] OP_JAL  = 5'b10101;
    localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    localparam logic [STATE_W-1:0] S_IDLE = 4'd0;
    localparam logic [STATE_W-1:0] S_T0   = 4'd1;
    localparam logic [STATE_W-1:0] S_T1   = 4'd2;
    localparam logic [STATE_W-1:0] S_T2   = 4'd3;
    localparam logic [STATE_W-1:0] S_T3   = 4'd4;
    localparam logic [STATE_W-1:0] S_T4   = 4'd5;
    localparam logic [STATE_W-1:0] S_T5   = 4'd6;
    localparam logic [STATE_W-1:0] S_T6   = 4'd7;
    localparam logic [STATE_W-1:0] S_T7   = 4'd8;
    localparam logic [STATE_W-1:0] S_HALT = 4'd15;

    typedef enum logic [3:0] {
        CLS_ALU, CLS_IMM, CLS_UNARY, CLS_MULDIV,
        CLS_LD, CLS_LDI, CLS_ST, CLS_BR,
        CLS_JR, CLS_JAL, CLS_MFHI, CLS_MFLO,
        CLS_IN, CLS_OUT, CLS_NOP, CLS_HALT
    } op_class_t;

    // Final execute step of each class; the edge after it is the instruction boundary.
    function automatic logic [STATE_W-1:0] last_step(input op_class_t cls);
        case (cls)
            CLS_ALU, CLS_IMM, CLS_LDI: return S_T5;
            CLS_UNARY, CLS_JAL:        return S_T4;
            CLS_MULDIV, CLS_BR:        return S_T6;
            CLS_LD, CLS_ST:            return S_T7;
            default:                   return S_T3;
        endcase
    endfunction

endpackage

// File: rtl/cu_op_class.sv
// Opcode to instruction-class decoder; undefined opcodes behave as nop.
module cu_op_class
    import cpu_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output op_class_t       cls
);

    // Map each opcode to the class that selects its execute sequence
    always_comb begin
        cls = CLS_NOP;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  cls = CLS_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:         cls = CLS_IMM;
            OP_NEG, OP_NOT:                   cls = CLS_UNARY;
            OP_MUL, OP_DIV:                   cls = CLS_MULDIV;
            OP_LD:                            cls = CLS_LD;
            OP_LDI:                           cls = CLS_LDI;
            OP_ST:                            cls = CLS_ST;
            OP_BR:                            cls = CLS_BR;
            OP_JR:                            cls = CLS_JR;
            OP_JAL:                           cls = CLS_JAL;
            OP_MFHI:                          cls = CLS_MFHI;
            OP_MFLO:                          cls = CLS_MFLO;
            OP_IN:                            cls = CLS_IN;
            OP_OUT:                           cls = CLS_OUT;
            OP_HALT:                          cls = CLS_HALT;
            default:                          cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired step sequencer for the Mini SRC DataPath.
//   state  | meaning
//   IDLE   | out of reset, nothing issued
//   T0-T2  | instruction fetch
//   T3-T7  | class-specific execute steps
//   HALT   | stopped, only clr leaves
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic               Clock,
    input  logic               clr,
    input  logic [IR_W-1:0]    IR,
    input  logic               CON_FF,
    input  logic               Stop,
    output logic               Run,
    output logic [STATE_W-1:0] T_state,
    output logic [OP_W-1:0]    opcode,
    output logic PC_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, MDR_out, in_port_out, BA_out,
    output logic MAR_enable, MDR_enable, PC_enable, IR_enable, Y_enable, Z_enable, HI_enable, LO_enable,
    output logic IncPC, Read, RAM_write_enable, con_in, out_port_enable, in_port_enable,
    output logic Gra, Grb, Grc, R_in, R_out
);

    logic [STATE_W-1:0] state, state_next;
    logic [OP_W-1:0]    op_ir;
    op_class_t          cls;

    // Register fields are consumed by the DataPath's own select logic, not here.
    logic unused_ir_fields;
    assign unused_ir_fields = ^IR[IR_W-OP_W-1:0];

    assign op_ir   = IR[IR_W-1 -: OP_W];
    assign T_state = state;
    assign Run     = (state >= S_T0) && (state <= S_T7);

    cu_op_class u_op_class (
        .op  (op_ir),
        .cls (cls)
    );

    // Step register
    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) state <= S_IDLE;
        else      state <= state_next;
    end

    // Step sequencing: fetch, then execute until the class's final step
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE: state_next = S_T0;
            S_T0:   state_next = S_T1;
            S_T1:   state_next = S_T2;
            S_T2:   state_next = S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (state == S_T3 && cls == CLS_HALT)
                    state_next = S_HALT;
                else if (state == last_step(cls))
                    state_next = Stop ? S_HALT : S_T0;
                else
                    state_next = state + STATE_W'(1);
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobe decode from the current step and instruction class
    always_comb begin
        opcode = '0;
        PC_out = 1'b0; ZLow_out = 1'b0; ZHigh_out = 1'b0; HI_out = 1'b0; LO_out = 1'b0;
        C_out = 1'b0; MDR_out = 1'b0; in_port_out = 1'b0; BA_out = 1'b0;
        MAR_enable = 1'b0; MDR_enable = 1'b0; PC_enable = 1'b0; IR_enable = 1'b0;
        Y_enable = 1'b0; Z_enable = 1'b0; HI_enable = 1'b0; LO_enable = 1'b0;
        IncPC = 1'b0; Read = 1'b0; RAM_write_enable = 1'b0; con_in = 1'b0;
        out_port_enable = 1'b0; in_port_enable = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; R_in = 1'b0; R_out = 1'b0;
        case (state)
            S_T0: begin PC_out = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; PC_enable = 1'b1; end
            S_T1: begin Read = 1'b1; MDR_enable = 1'b1; end
            S_T2: begin MDR_out = 1'b1; IR_enable = 1'b1; end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                case (cls)
                    CLS_ALU, CLS_IMM: begin
                        if (state == S_T3) begin
                            Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1;
                        end else if (state == S_T4) begin
                            if (cls == CLS_IMM) C_out = 1'b1;
                            else begin Grc = 1'b1; R_out = 1'b1; end
                            Z_enable = 1'b1; opcode = op_ir;
                        end else if (state == S_T5) begin
                            ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1;
                        end
                    end
                    CLS_UNARY: begin
                        if (state == S_T3) begin
                            Grb = 1'b1; R_out = 1'b1; Z_enable = 1'b1; opcode = op_ir;
                        end else if (state == S_T4) begin
                            ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1;
                        end
                    end
                    CLS_MULDIV: begin
                        if (state == S_T3) begin
                            Gra = 1'b1; R_out = 1'b1; Y_enable = 1'b1;
                        end else if (state == S_T4) begin
                            Grb = 1'b1; R_out = 1'b1; Z_enable = 1'b1; opcode = op_ir;
                        end else if (state == S_T5) begin
                            ZLow_out = 1'b1; LO_enable = 1'b1;
                        end else if (state == S_T6) begin
                            ZHigh_out = 1'b1; HI_enable = 1'b1;
                        end
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        if (state == S_T3) begin
                            Grb = 1'b1; BA_out = 1'b1; Y_enable = 1'b1;
                        end else if (state == S_T4) begin
                            C_out = 1'b1; Z_enable = 1'b1; opcode = OP_ADD;
                        end else if (state == S_T5) begin
                            ZLow_out = 1'b1;
                            if (cls == CLS_LDI) begin Gra = 1'b1; R_in = 1'b1; end
                            else MAR_enable = 1'b1;
                        end else if (state == S_T6) begin
                            MDR_enable = 1'b1;
                            if (cls == CLS_ST) begin Gra = 1'b1; R_out = 1'b1; end
                            else Read = 1'b1;
                        end else if (state == S_T7) begin
                            if (cls == CLS_ST) RAM_write_enable = 1'b1;
                            else begin MDR_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                        end
                    end
                    CLS_BR: begin
                        if (state == S_T3) begin
                            Gra = 1'b1; R_out = 1'b1; con_in = 1'b1;
                        end else if (state == S_T4) begin
                            PC_out = 1'b1; Y_enable = 1'b1;
                        end else if (state == S_T5) begin
                            C_out = 1'b1; Z_enable = 1'b1; opcode = OP_ADD;
                        end else if (state == S_T6) begin
                            ZLow_out = 1'b1; PC_enable = CON_FF;
                        end
                    end
                    CLS_JR:   if (state == S_T3) begin Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; end
                    CLS_JAL: begin
                        if (state == S_T3) begin
                            PC_out = 1'b1; Grb = 1'b1; R_in = 1'b1;
                        end else if (state == S_T4) begin
                            Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1;
                        end
                    end
                    CLS_MFHI: if (state == S_T3) begin HI_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    CLS_MFLO: if (state == S_T3) begin LO_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    CLS_IN:   if (state == S_T3) begin in_port_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    CLS_OUT:  if (state == S_T3) begin Gra = 1'b1; R_out = 1'b1; out_port_enable = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level model pushes the
// expected per-step strobe pattern; a monitor compares one entry per clock.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        clr, CON_FF, Stop;
    logic [31:0] IR;
    logic        Run;
    logic [3:0]  T_state;
    logic [4:0]  opcode;
    logic PC_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, MDR_out, in_port_out, BA_out;
    logic MAR_enable, MDR_enable, PC_enable, IR_enable, Y_enable, Z_enable, HI_enable, LO_enable;
    logic IncPC, Read, RAM_write_enable, con_in, out_port_enable, in_port_enable;
    logic Gra, Grb, Grc, R_in, R_out;

    control_unit dut (
        .Clock(Clock), .clr(clr), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .Run(Run), .T_state(T_state), .opcode(opcode),
        .PC_out(PC_out), .ZLow_out(ZLow_out), .ZHigh_out(ZHigh_out), .HI_out(HI_out),
        .LO_out(LO_out), .C_out(C_out), .MDR_out(MDR_out), .in_port_out(in_port_out),
        .BA_out(BA_out), .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
        .PC_enable(PC_enable), .IR_enable(IR_enable), .Y_enable(Y_enable),
        .Z_enable(Z_enable), .HI_enable(HI_enable), .LO_enable(LO_enable),
        .IncPC(IncPC), .Read(Read), .RAM_write_enable(RAM_write_enable), .con_in(con_in),
        .out_port_enable(out_port_enable), .in_port_enable(in_port_enable),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in), .R_out(R_out)
    );

    always #5 Clock = ~Clock;

    // Strobe vector bit masks
    localparam logic [27:0] M_PCOUT  = 28'h1 << 27, M_ZLOW   = 28'h1 << 26, M_ZHIGH  = 28'h1 << 25;
    localparam logic [27:0] M_HIOUT  = 28'h1 << 24, M_LOOUT  = 28'h1 << 23, M_COUT   = 28'h1 << 22;
    localparam logic [27:0] M_MDROUT = 28'h1 << 21, M_INPOUT = 28'h1 << 20, M_BAOUT  = 28'h1 << 19;
    localparam logic [27:0] M_MAR    = 28'h1 << 18, M_MDREN  = 28'h1 << 17, M_PCEN   = 28'h1 << 16;
    localparam logic [27:0] M_IREN   = 28'h1 << 15, M_YEN    = 28'h1 << 14, M_ZEN    = 28'h1 << 13;
    localparam logic [27:0] M_HIEN   = 28'h1 << 12, M_LOEN   = 28'h1 << 11, M_INCPC  = 28'h1 << 10;
    localparam logic [27:0] M_READ   = 28'h1 << 9,  M_RAMW   = 28'h1 << 8,  M_CONIN  = 28'h1 << 7;
    localparam logic [27:0] M_OUTPEN = 28'h1 << 6,  M_INPEN  = 28'h1 << 5,  M_GRA    = 28'h1 << 4;
    localparam logic [27:0] M_GRB    = 28'h1 << 3,  M_GRC    = 28'h1 << 2,  M_RIN    = 28'h1 << 1;
    localparam logic [27:0] M_ROUT   = 28'h1;
    localparam logic [27:0] M_BUS = M_PCOUT | M_ZLOW | M_ZHIGH | M_HIOUT | M_LOOUT | M_COUT |
                                    M_MDROUT | M_INPOUT | M_BAOUT | M_ROUT;

    localparam logic [3:0] ST_IDLE = 4'd0, ST_HALT = 4'd15;
    localparam logic [4:0] Z5 = 5'd0, ADD_OP = 5'b00011;

    typedef struct { logic [3:0] st; logic [27:0] sig; logic [4:0] op; logic run; } exp_t;
    typedef struct packed { logic [27:0] sig; logic [4:0] op; } step_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [27:0] sig_now();
        return {PC_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, MDR_out, in_port_out, BA_out,
                MAR_enable, MDR_enable, PC_enable, IR_enable, Y_enable, Z_enable, HI_enable, LO_enable,
                IncPC, Read, RAM_write_enable, con_in, out_port_enable, in_port_enable,
                Gra, Grb, Grc, R_in, R_out};
    endfunction

    task automatic push_item(input logic [3:0] st, input logic [27:0] s, input logic [4:0] o);
        exp_t e;
        e.st = st; e.sig = s; e.op = o;
        e.run = (st != ST_IDLE) && (st != ST_HALT);
        exp_q.push_back(e);
    endtask

    // Reference: the full step list of one instruction, written per instruction
    task automatic push_instr(input logic [31:0] ir, input logic con, output int n);
        step_t q[$];
        logic [4:0] op;
        op = ir[31:27];
        q.push_back({M_PCOUT | M_MAR | M_INCPC | M_PCEN, Z5});
        q.push_back({M_READ | M_MDREN, Z5});
        q.push_back({M_MDROUT | M_IREN, Z5});
        if (op inside {[5'd3:5'd11]}) begin
            q.push_back({M_GRB | M_ROUT | M_YEN, Z5});
            q.push_back({M_GRC | M_ROUT | M_ZEN, op});
            q.push_back({M_ZLOW | M_GRA | M_RIN, Z5});
        end else if (op inside {[5'd12:5'd14]}) begin
            q.push_back({M_GRB | M_ROUT | M_YEN, Z5});
            q.push_back({M_COUT | M_ZEN, op});
            q.push_back({M_ZLOW | M_GRA | M_RIN, Z5});
        end else if (op == 5'd17 || op == 5'd18) begin
            q.push_back({M_GRB | M_ROUT | M_ZEN, op});
            q.push_back({M_ZLOW | M_GRA | M_RIN, Z5});
        end else if (op == 5'd15 || op == 5'd16) begin
            q.push_back({M_GRA | M_ROUT | M_YEN, Z5});
            q.push_back({M_GRB | M_ROUT | M_ZEN, op});
            q.push_back({M_ZLOW | M_LOEN, Z5});
            q.push_back({M_ZHIGH | M_HIEN, Z5});
        end else if (op <= 5'd2) begin
            q.push_back({M_GRB | M_BAOUT | M_YEN, Z5});
            q.push_back({M_COUT | M_ZEN, ADD_OP});
            if (op == 5'd1) begin
                q.push_back({M_ZLOW | M_GRA | M_RIN, Z5});
            end else if (op == 5'd0) begin
                q.push_back({M_ZLOW | M_MAR, Z5});
                q.push_back({M_READ | M_MDREN, Z5});
                q.push_back({M_MDROUT | M_GRA | M_RIN, Z5});
            end else begin
                q.push_back({M_ZLOW | M_MAR, Z5});
                q.push_back({M_GRA | M_ROUT | M_MDREN, Z5});
                q.push_back({M_RAMW, Z5});
            end
        end else if (op == 5'd19) begin
            q.push_back({M_GRA | M_ROUT | M_CONIN, Z5});
            q.push_back({M_PCOUT | M_YEN, Z5});
            q.push_back({M_COUT | M_ZEN, ADD_OP});
            q.push_back({M_ZLOW | (con ? M_PCEN : 28'd0), Z5});
        end else if (op == 5'd20) begin
            q.push_back({M_GRA | M_ROUT | M_PCEN, Z5});
        end else if (op == 5'd21) begin
            q.push_back({M_PCOUT | M_GRB | M_RIN, Z5});
            q.push_back({M_GRA | M_ROUT | M_PCEN, Z5});
        end else if (op == 5'd22) q.push_back({M_INPOUT | M_GRA | M_RIN, Z5});
        else if (op == 5'd23)     q.push_back({M_GRA | M_ROUT | M_OUTPEN, Z5});
        else if (op == 5'd24)     q.push_back({M_HIOUT | M_GRA | M_RIN, Z5});
        else if (op == 5'd25)     q.push_back({M_LOOUT | M_GRA | M_RIN, Z5});
        else                      q.push_back({28'd0, Z5});
        n = q.size();
        for (int i = 0; i < n; i++) push_item(4'(i + 1), q[i].sig, q[i].op);
    endtask

    task automatic check_idle(input string name);
        total++;
        if (T_state !== ST_IDLE || sig_now() !== 28'd0 || opcode !== 5'd0 || Run !== 1'b0) begin
            bad++;
            $display("FAIL %s: got st=%0d sig=%h op=%b run=%b, want st=0 sig=0 op=0 run=0",
                     name, T_state, sig_now(), opcode, Run);
        end
    endtask

    // Entry: at a negedge just before the instruction's T0 edge.
    // Exit: at the negedge of its last step (or after clr if aborted).
    task automatic run_instr(input logic [31:0] ir, input logic con, input int stop_k, input int abort_k);
        int n;
        push_instr(ir, con, n);
        @(negedge Clock);
        IR = ir; CON_FF = con;
        for (int k = 1; k < n; k++) begin
            @(negedge Clock);
            if (k == stop_k) Stop = 1'b1;
            if (k == abort_k) begin
                clr = 1'b0;
                #1;
                exp_q.delete();
                check_idle("clr_mid_instr");
                return;
            end
        end
    endtask

    task automatic reset_release(input string name);
        @(negedge Clock);
        Stop = 1'b0;
        clr  = 1'b1;
        #1 check_idle(name);
    endtask

    task automatic expect_halt(input int cycles);
        for (int i = 0; i < cycles; i++) push_item(ST_HALT, 28'd0, Z5);
        repeat (cycles) @(negedge Clock);
    endtask

    // Monitor: one scoreboard entry per clock, plus the bus-driver exclusivity check
    always begin
        @(posedge Clock);
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (T_state !== e.st || sig_now() !== e.sig || opcode !== e.op || Run !== e.run) begin
                bad++;
                $display("FAIL step: got st=%0d sig=%h op=%b run=%b, want st=%0d sig=%h op=%b run=%b",
                         T_state, sig_now(), opcode, Run, e.st, e.sig, e.op, e.run);
            end
        end
        total++;
        if ($countones(sig_now() & M_BUS) > 1) begin
            bad++;
            $display("FAIL bus_drivers: got %0d drivers (sig=%h), want at most 1",
                     $countones(sig_now() & M_BUS), sig_now());
        end
    end

    initial begin
        logic [31:0] ir;
        logic [4:0]  op;
        clr = 1'b0; IR = 32'd0; CON_FF = 1'b0; Stop = 1'b0;
        repeat (3) @(negedge Clock);
        check_idle("reset");
        clr = 1'b1;
        #1 check_idle("idle_after_release");

        run_instr(32'h1A920000, 1'b0, -1, 4);   // add aborted by clr in T4
        repeat (2) @(negedge Clock);
        check_idle("held_in_clr");
        reset_release("idle_after_clr");

        run_instr(32'h1A920000, 1'b0, -1, -1);  // add r5,r2,r4
        run_instr(32'hA3000000, 1'b0, -1, -1);  // jr r6
        run_instr(32'h99000023, 1'b0, -1, -1);  // br, not taken
        run_instr(32'h99000023, 1'b1, -1, -1);  // br, taken
        run_instr(32'h00800055, 1'b0, -1, -1);  // ld r1,0x55(r0)

        for (int i = 0; i < 80; i++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            ir = {op, 27'($urandom)};
            run_instr(ir, 1'($urandom_range(0, 1)), -1, -1);
        end

        run_instr(32'h1A920000, 1'b0, 4, -1);   // Stop raised in T4 of add
        expect_halt(5);
        clr = 1'b0;
        #1 check_idle("clr_from_stop_halt");
        reset_release("idle_after_stop");

        run_instr(32'hD8000000, 1'b0, -1, -1);  // halt
        expect_halt(20);
        clr = 1'b0;
        #1 check_idle("clr_from_halt");

        repeat (3) @(negedge Clock);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
